// File: rtl/perf_event_reader.sv
// Perf-event counter bank with atomic snapshot and valid/ready streaming readout.
// Optional macro PERF_SATURATE_EN: saturating counters plus an out_sat beat flag.
module perf_event_reader #(
    parameter int EVENT_NUM = 16,
    parameter int CNT_WIDTH = 32,
    localparam int ID_WIDTH = $clog2(EVENT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EVENT_NUM-1:0] event_i,
    input  logic                 clear,
    input  logic                 dump_req,
    output logic                 dump_busy,
    output logic                 out_valid,
    output logic [ID_WIDTH-1:0]  out_id,
    output logic [CNT_WIDTH-1:0] out_data,
    output logic                 out_last,
`ifdef PERF_SATURATE_EN
    output logic                 out_sat,
`endif
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(EVENT_NUM - 1);
`ifdef PERF_SATURATE_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`endif

    state_t               state;
    logic [ID_WIDTH-1:0]  idx;
    logic [ID_WIDTH-1:0]  idx_nxt;
    logic [CNT_WIDTH-1:0] cnt    [EVENT_NUM];
    logic [CNT_WIDTH-1:0] shadow [EVENT_NUM];

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_SATURATE_EN
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
`else
        return v + CNT_WIDTH'(1);
`endif
    endfunction

`ifdef PERF_SATURATE_EN
    function automatic logic is_sat(input logic [CNT_WIDTH-1:0] v);
        return v == CNT_MAX;
    endfunction
`endif

    assign out_id  = idx;
    assign idx_nxt = idx + ID_WIDTH'(1);

    // Live counters: clear wins over a same-cycle event, counting never pauses for a dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EVENT_NUM; i++) cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < EVENT_NUM; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < EVENT_NUM; i++)
                if (event_i[i]) cnt[i] <= cnt_inc(cnt[i]);
        end
    end

    // Snapshot/stream FSM; shadow captures pre-edge counts so a coincident clear is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dump_busy <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
`ifdef PERF_SATURATE_EN
            out_sat   <= 1'b0;
`endif
            for (int i = 0; i < EVENT_NUM; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        for (int i = 0; i < EVENT_NUM; i++) shadow[i] <= cnt[i];
                        dump_busy <= 1'b1;
                        state     <= SNAP;
                    end
                end
                SNAP: begin
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_data  <= shadow[0];
                    out_last  <= (LAST_ID == '0);
`ifdef PERF_SATURATE_EN
                    out_sat   <= is_sat(shadow[0]);
`endif
                    state     <= DUMP;
                end
                DUMP: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            dump_busy <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= shadow[idx_nxt];
                            out_last <= (idx_nxt == LAST_ID);
`ifdef PERF_SATURATE_EN
                            out_sat  <= is_sat(shadow[idx_nxt]);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_event_reader.sv
// Directed bench for perf_event_reader: a 32-bit and a 4-bit instance driven in lockstep.
module tb_perf_event_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] event_i = '0;
    logic        clear = 1'b0;
    logic        dump_req = 1'b0;
    logic        out_ready = 1'b1;

    logic        dump_busy, out_valid, out_last;
    logic [3:0]  out_id;
    logic [31:0] out_data;
    logic        dump_busy4, out_valid4, out_last4;
    logic [3:0]  out_id4;
    logic [3:0]  out_data4;
`ifdef PERF_SATURATE_EN
    logic        out_sat, out_sat4;
`endif

    perf_event_reader #(.EVENT_NUM(16), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .event_i(event_i), .clear(clear), .dump_req(dump_req),
        .dump_busy(dump_busy), .out_valid(out_valid), .out_id(out_id),
        .out_data(out_data), .out_last(out_last),
`ifdef PERF_SATURATE_EN
        .out_sat(out_sat),
`endif
        .out_ready(out_ready)
    );

    perf_event_reader #(.EVENT_NUM(16), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .event_i(event_i), .clear(clear), .dump_req(dump_req),
        .dump_busy(dump_busy4), .out_valid(out_valid4), .out_id(out_id4),
        .out_data(out_data4), .out_last(out_last4),
`ifdef PERF_SATURATE_EN
        .out_sat(out_sat4),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_data  [16];
    logic [3:0]  cap_data4 [16];
    logic        cap_sat4  [16];
    int nbeats, lat, vcycles, total;
    logic [31:0] first_val;

    typedef struct {
        logic [15:0] mask;
        int          cycles;
    } stim_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; event_i = '0; clear = 1'b0; dump_req = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input logic [15:0] mask, input int n);
        event_i = mask;
        repeat (n) @(negedge clk);
        event_i = '0;
    endtask

    // Starts at a negedge; optionally stalls one beat and/or re-pulses dump_req mid-stream.
    task automatic do_dump(input int stall_id, input int stall_n, input int repulse_id,
                           input bit clr_with_req);
        int stalled;
        bit prev_stall;
        logic [3:0]  pid;
        logic [31:0] pd;
        nbeats = 0; lat = -1; vcycles = 0; total = -1; stalled = 0; prev_stall = 0;
        pid = '0; pd = '0;
        for (int i = 0; i < 16; i++) begin
            cap_data[i] = 'x; cap_data4[i] = 'x; cap_sat4[i] = 1'bx;
        end
        dump_req = 1'b1; clear = clr_with_req; out_ready = 1'b1;
        for (int c = 1; c <= 200 && total < 0; c++) begin
            @(negedge clk);
            dump_req = 1'b0; clear = 1'b0;
            if (out_valid) begin
                vcycles++;
                if (lat < 0) lat = c;
                if (prev_stall) begin
                    chk("stall_id_stable", 64'(out_id), 64'(pid));
                    chk("stall_data_stable", 64'(out_data), 64'(pd));
                end
                if (int'(out_id) == stall_id && stalled < stall_n) begin
                    out_ready = 1'b0; stalled++; prev_stall = 1'b1;
                    pid = out_id; pd = out_data;
                end else begin
                    out_ready = 1'b1; prev_stall = 1'b0;
                    if (nbeats < 16) begin
                        cap_data[nbeats]  = out_data;
                        cap_data4[nbeats] = out_data4;
`ifdef PERF_SATURATE_EN
                        cap_sat4[nbeats]  = out_sat4;
`endif
                    end
                    chk("beat_id", 64'(out_id), 64'(nbeats));
                    chk("beat_last", 64'(out_last), 64'(nbeats == 15));
                    nbeats++;
                    if (int'(out_id) == repulse_id) dump_req = 1'b1;
                end
            end else if (!dump_busy) begin
                total = c;
            end
        end
        out_ready = 1'b1;
        if (total < 0) chk("dump_timeout", 64'(0), 64'(1));
    endtask

    stim_t stim [3];
    exp_t  expv [16];
    bit    found;

    initial begin
        // Reset state
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(dump_busy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_id", 64'(out_id), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic dump: event 3 for 5 cycles, event 0 for 2 cycles
        stim[0] = '{16'h0009, 2};
        stim[1] = '{16'h0008, 3};
        stim[2] = '{16'h0000, 1};
        for (int i = 0; i < 16; i++) expv[i] = '{i, 32'd0};
        expv[0].data = 32'd2;
        expv[3].data = 32'd5;
        for (int i = 0; i < 3; i++) apply(stim[i].mask, stim[i].cycles);
        do_dump(-1, 0, -1, 1'b0);
        chk("basic_latency", 64'(lat), 64'(2));
        chk("basic_beats", 64'(nbeats), 64'(16));
        chk("basic_total", 64'(total), 64'(18));
        for (int i = 0; i < 16; i++)
            chk($sformatf("basic_beat%0d", expv[i].idx), 64'(cap_data[expv[i].idx]), 64'(expv[i].data));

        // event 1 held continuously; request at cycle 10 after release
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; event_i = 16'h0002;
        repeat (10) @(negedge clk);
        do_dump(-1, 0, -1, 1'b0);
        chk("cont_beat1", 64'(cap_data[1]), 64'(10));
        first_val = cap_data[1];
        do_dump(-1, 0, -1, 1'b0);
        chk("cont_grows", 64'(cap_data[1] > first_val), 64'(1));
        event_i = '0;

        // Backpressure on beat 4
        do_reset();
        apply(16'h0030, 1);
        apply(16'h0010, 2);
        do_dump(4, 3, -1, 1'b0);
        chk("bp_valid_cycles", 64'(vcycles), 64'(19));
        chk("bp_total", 64'(total), 64'(21));
        chk("bp_beat4", 64'(cap_data[4]), 64'(3));
        chk("bp_beat5", 64'(cap_data[5]), 64'(1));

        // clear beats a same-cycle event
        do_reset();
        apply(16'h0004, 7);
        clear = 1'b1; event_i = 16'h0004;
        @(negedge clk);
        clear = 1'b0; event_i = '0;
        do_dump(-1, 0, -1, 1'b0);
        chk("clr_event_beat2", 64'(cap_data[2]), 64'(0));

        // clear together with dump_req: snapshot sees pre-clear value
        do_reset();
        apply(16'h0004, 7);
        do_dump(-1, 0, -1, 1'b1);
        chk("clr_req_beat2", 64'(cap_data[2]), 64'(7));
        do_dump(-1, 0, -1, 1'b0);
        chk("clr_req_after", 64'(cap_data[2]), 64'(0));

        // dump_req re-pulsed mid-stream is dropped
        apply(16'h0100, 2);
        do_dump(-1, 0, 8, 1'b0);
        chk("repulse_beats", 64'(nbeats), 64'(16));
        chk("repulse_beat8", 64'(cap_data[8]), 64'(2));
        repeat (3) begin
            @(negedge clk);
            chk("repulse_idle", 64'(dump_busy), 64'(0));
        end

        // Async reset at beat 6
        apply(16'h0080, 3);
        dump_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            dump_req = 1'b0;
            if (out_valid && out_id == 4'd6) found = 1'b1;
        end
        chk("rst_mid_reached", 64'(found), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_busy", 64'(dump_busy), 64'(0));
        chk("rst_mid_last", 64'(out_last), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resume", 64'(out_valid), 64'(0));
        do_dump(-1, 0, -1, 1'b0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("post_rst_beat%0d", i), 64'(cap_data[i]), 64'(0));

        // Overflow of the 4-bit instance
        do_reset();
        apply(16'h0001, 20);
        do_dump(-1, 0, -1, 1'b0);
        chk("ovf32_beat0", 64'(cap_data[0]), 64'(20));
`ifdef PERF_SATURATE_EN
        chk("sat4_beat0", 64'(cap_data4[0]), 64'(15));
        for (int i = 0; i < 16; i++)
            chk($sformatf("sat4_flag%0d", i), 64'(cap_sat4[i]), 64'(i == 0));
`else
        chk("wrap4_beat0", 64'(cap_data4[0]), 64'(4));
        chk("wrap4_beat1", 64'(cap_data4[1]), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
